// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_if
// Description : CPU-side single-outstanding req/ack bus into sram_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  rdata_o, ack_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output rdata_o, ack_o, err_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Sequences CE/OE/WE strobes and data-bus tristates for two
//               asynchronous 32-bit SRAM banks behind a req/ack bus.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,
    sram_ctrl_if.slave       bus,

    output logic             base_ce_n_o,
    output logic             base_oe_n_o,
    output logic             base_we_n_o,
    output logic [3:0]       base_be_n_o,
    output logic [19:0]      base_addr_o,
    inout  wire logic [31:0] base_data_io,

    output logic             ext_ce_n_o,
    output logic             ext_oe_n_o,
    output logic             ext_we_n_o,
    output logic [3:0]       ext_be_n_o,
    output logic [19:0]      ext_addr_o,
    inout  wire logic [31:0] ext_data_io
);

    localparam int         c_STATE_W   = 3;
    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [c_STATE_W-1:0] {
        c_IDLE   = 3'd0,
        c_SETUP  = 3'd1,
        c_ACCESS = 3'd2,
        c_HOLD   = 3'd3,
        c_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_bank;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;

    // Pin-side registers, index 0 = base bank, index 1 = ext bank
    logic [1:0]        r_ce_n;
    logic [1:0]        r_oe_n;
    logic [1:0]        r_we_n;
    logic [1:0]        r_drv;
    logic [1:0][3:0]   r_be_n;
    logic [1:0][19:0]  r_addr;

    logic              w_bad_addr;
    logic [31:0]       w_bank_rdata;

    assign w_bad_addr   = (bus.addr_i[31:23] != 9'd0) || (bus.addr_i[1:0] != 2'd0);
    assign w_bank_rdata = r_bank ? ext_data_io : base_data_io;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_bank  <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_ce_n  <= '1;
            r_oe_n  <= '1;
            r_we_n  <= '1;
            r_drv   <= '0;
            r_be_n  <= '1;
            r_addr  <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.req_i) begin
                        r_we    <= bus.we_i;
                        r_wdata <= bus.wdata_i;
                        r_bank  <= bus.addr_i[22];
                        r_busy  <= 1'b1;
                        if (w_bad_addr) begin
                            // Rejected requests never touch the pins
                            r_state <= c_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state                <= c_SETUP;
                            r_err                  <= 1'b0;
                            r_ce_n[bus.addr_i[22]] <= 1'b0;
                            r_oe_n[bus.addr_i[22]] <= bus.we_i;
                            r_be_n[bus.addr_i[22]] <= bus.we_i ? ~bus.be_i : 4'b0000;
                            r_addr[bus.addr_i[22]] <= bus.addr_i[21:2];
                            r_drv[bus.addr_i[22]]  <= bus.we_i;
                        end
                    end
                end
                c_SETUP: begin
                    r_state <= c_ACCESS;
                    r_cnt   <= c_WAIT_LAST;
                    if (r_we) begin
                        r_we_n[r_bank] <= 1'b0;
                    end
                end
                c_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (r_we) begin
                            r_state        <= c_HOLD;
                            r_we_n[r_bank] <= 1'b1;
                        end else begin
                            r_state <= c_DONE;
                            r_ack   <= 1'b1;
                            r_rdata <= w_bank_rdata;
                            r_ce_n  <= '1;
                            r_oe_n  <= '1;
                            r_be_n  <= '1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_HOLD: begin
                    // Data stays on the bus through this cycle for hold time
                    r_state <= c_DONE;
                    r_ack   <= 1'b1;
                    r_ce_n  <= '1;
                    r_be_n  <= '1;
                    r_drv   <= '0;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata_o = r_rdata;
    assign bus.ack_o   = r_ack;
    assign bus.err_o   = r_err;
    assign bus.busy_o  = r_busy;

    assign base_ce_n_o  = r_ce_n[0];
    assign base_oe_n_o  = r_oe_n[0];
    assign base_we_n_o  = r_we_n[0];
    assign base_be_n_o  = r_be_n[0];
    assign base_addr_o  = r_addr[0];
    assign base_data_io = r_drv[0] ? r_wdata : 32'bz;

    assign ext_ce_n_o   = r_ce_n[1];
    assign ext_oe_n_o   = r_oe_n[1];
    assign ext_we_n_o   = r_we_n[1];
    assign ext_be_n_o   = r_be_n[1];
    assign ext_addr_o   = r_addr[1];
    assign ext_data_io  = r_drv[1] ? r_wdata : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Directed self-checking bench for sram_ctrl with two SRAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    logic clk;
    logic rst_n;

    sram_ctrl_if bus();

    logic        base_ce_n_o, base_oe_n_o, base_we_n_o;
    logic [3:0]  base_be_n_o;
    logic [19:0] base_addr_o;
    wire  [31:0] base_data_io;
    logic        ext_ce_n_o, ext_oe_n_o, ext_we_n_o;
    logic [3:0]  ext_be_n_o;
    logic [19:0] ext_addr_o;
    wire  [31:0] ext_data_io;

    sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .bus          (bus),
        .base_ce_n_o  (base_ce_n_o),
        .base_oe_n_o  (base_oe_n_o),
        .base_we_n_o  (base_we_n_o),
        .base_be_n_o  (base_be_n_o),
        .base_addr_o  (base_addr_o),
        .base_data_io (base_data_io),
        .ext_ce_n_o   (ext_ce_n_o),
        .ext_oe_n_o   (ext_oe_n_o),
        .ext_we_n_o   (ext_we_n_o),
        .ext_be_n_o   (ext_be_n_o),
        .ext_addr_o   (ext_addr_o),
        .ext_data_io  (ext_data_io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small SRAM models: 256 words each, byte-lane writes while CE and WE are low
    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];

    assign base_data_io = (!base_ce_n_o && !base_oe_n_o && base_we_n_o) ? base_mem[base_addr_o[7:0]] : 32'bz;
    assign ext_data_io  = (!ext_ce_n_o && !ext_oe_n_o && ext_we_n_o) ? ext_mem[ext_addr_o[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (!base_ce_n_o && !base_we_n_o) begin
            for (int i = 0; i < 4; i++)
                if (!base_be_n_o[i]) base_mem[base_addr_o[7:0]][8*i +: 8] <= base_data_io[8*i +: 8];
        end
        if (!ext_ce_n_o && !ext_we_n_o) begin
            for (int j = 0; j < 4; j++)
                if (!ext_be_n_o[j]) ext_mem[ext_addr_o[7:0]][8*j +: 8] <= ext_data_io[8*j +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    // Observations of the most recent transaction (index 0 = base, 1 = ext)
    int          n_ce [2];
    int          n_oe [2];
    int          n_we [2];
    int          n_act[2];
    int          n_drv[2];
    logic [19:0] cap_addr[2];
    logic [3:0]  cap_be_n[2];
    int          ack_cyc;
    int          busy_bad;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        ack_after;
    logic        busy_after;

    // Called just after a rising edge; the next edge is cycle 0.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        logic [1:0] ce_v, oe_v, we_v;
        logic [3:0] be_v [2];
        for (int b = 0; b < 2; b++) begin
            n_ce[b] = 0; n_oe[b] = 0; n_we[b] = 0; n_act[b] = 0; n_drv[b] = 0;
            cap_addr[b] = '0; cap_be_n[b] = '0;
        end
        ack_cyc = 0; busy_bad = 0; got_rdata = '0; got_err = 1'b0;
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata; bus.be_i = be;
        @(posedge clk);
        for (int k = 1; k <= 24 && ack_cyc == 0; k++) begin
            @(negedge clk);
            ce_v = {ext_ce_n_o, base_ce_n_o};
            oe_v = {ext_oe_n_o, base_oe_n_o};
            we_v = {ext_we_n_o, base_we_n_o};
            be_v[0] = base_be_n_o;
            be_v[1] = ext_be_n_o;
            for (int b = 0; b < 2; b++) begin
                if (!ce_v[b]) n_ce[b]++;
                if (!oe_v[b]) n_oe[b]++;
                if (!we_v[b]) n_we[b]++;
                if (!ce_v[b] || !oe_v[b] || !we_v[b] || be_v[b] != 4'hF) n_act[b]++;
            end
            if (we && base_data_io === wdata) n_drv[0]++;
            if (we && ext_data_io === wdata) n_drv[1]++;
            if (k == 1) begin
                cap_addr[0] = base_addr_o; cap_addr[1] = ext_addr_o;
                cap_be_n[0] = base_be_n_o; cap_be_n[1] = ext_be_n_o;
            end
            if (bus.busy_o !== 1'b1) busy_bad++;
            if (bus.ack_o === 1'b1) begin
                ack_cyc = k; got_rdata = bus.rdata_o; got_err = bus.err_o;
            end
        end
        bus.req_i = 1'b0;
        @(posedge clk);
        #1;
        ack_after = bus.ack_o;
        busy_after = bus.busy_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({base_ce_n_o, base_oe_n_o, base_we_n_o, ext_ce_n_o, ext_oe_n_o, ext_we_n_o} !== 6'b111111) begin
            errors++; $display("FAIL reset_strobes got %b want 111111", {base_ce_n_o, base_oe_n_o, base_we_n_o, ext_ce_n_o, ext_oe_n_o, ext_we_n_o}); end
        checks++; if ({base_be_n_o, ext_be_n_o} !== 8'hFF) begin
            errors++; $display("FAIL reset_be_n got %h want ff", {base_be_n_o, ext_be_n_o}); end
        checks++; if ({base_addr_o, ext_addr_o} !== 40'd0) begin
            errors++; $display("FAIL reset_addr got %h want 0", {base_addr_o, ext_addr_o}); end
        checks++; if ({bus.ack_o, bus.busy_o, bus.err_o} !== 3'b000 || bus.rdata_o !== 32'd0) begin
            errors++; $display("FAIL reset_bus got ack/busy/err %b rdata %h want 000 0", {bus.ack_o, bus.busy_o, bus.err_o}, bus.rdata_o); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_base();
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL wr_ack_cycle got %0d want 4", ack_cyc); end
        checks++; if (cap_addr[0] !== 20'h00004) begin errors++; $display("FAIL wr_base_addr got %h want 00004", cap_addr[0]); end
        checks++; if (n_we[0] !== 1) begin errors++; $display("FAIL wr_we_low_cycles got %0d want 1", n_we[0]); end
        checks++; if (n_drv[0] !== 3) begin errors++; $display("FAIL wr_data_drive_cycles got %0d want 3", n_drv[0]); end
        checks++; if (n_oe[0] !== 0) begin errors++; $display("FAIL wr_oe_low_cycles got %0d want 0", n_oe[0]); end
        checks++; if (cap_be_n[0] !== 4'h0) begin errors++; $display("FAIL wr_be_n got %h want 0", cap_be_n[0]); end
        checks++; if (n_act[1] !== 0) begin errors++; $display("FAIL wr_ext_idle got %0d active cycles want 0", n_act[1]); end
        checks++; if (got_err !== 1'b0 || busy_bad !== 0) begin errors++; $display("FAIL wr_err_busy got err %b busy_bad %0d want 0 0", got_err, busy_bad); end
        checks++; if (ack_after !== 1'b0 || busy_after !== 1'b0) begin errors++; $display("FAIL wr_after_ack got ack %b busy %b want 0 0", ack_after, busy_after); end
        checks++; if (base_mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_mem got %h want deadbeef", base_mem[4]); end
    endtask

    task automatic test_read_base();
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL rd_ack_cycle got %0d want 3", ack_cyc); end
        checks++; if (n_oe[0] !== 2) begin errors++; $display("FAIL rd_oe_low_cycles got %0d want 2", n_oe[0]); end
        checks++; if (got_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", got_rdata); end
        checks++; if (got_err !== 1'b0 || n_we[0] !== 0) begin errors++; $display("FAIL rd_err_we got err %b we_low %0d want 0 0", got_err, n_we[0]); end
    endtask

    task automatic test_write_ext();
        run_txn(1'b1, 32'h0040_0008, 32'hAABB_CCDD, 4'hF);
        run_txn(1'b1, 32'h0040_0008, 32'h1122_3344, 4'b0011);
        checks++; if (cap_addr[1] !== 20'h00002) begin errors++; $display("FAIL ext_addr got %h want 00002", cap_addr[1]); end
        checks++; if (cap_be_n[1] !== 4'b1100) begin errors++; $display("FAIL ext_be_n got %b want 1100", cap_be_n[1]); end
        checks++; if (ext_mem[2] !== 32'hAABB_3344) begin errors++; $display("FAIL ext_mem got %h want aabb3344", ext_mem[2]); end
        checks++; if (n_act[0] !== 0 || ack_cyc !== 4) begin errors++; $display("FAIL ext_base_idle got base_active %0d ack %0d want 0 4", n_act[0], ack_cyc); end
        run_txn(1'b0, 32'h0040_0008, 32'h0, 4'h0);
        checks++; if (got_rdata !== 32'hAABB_3344 || ack_cyc !== 3) begin errors++; $display("FAIL ext_readback got %h ack %0d want aabb3344 3", got_rdata, ack_cyc); end
    endtask

    task automatic test_reject();
        run_txn(1'b0, 32'h0080_0000, 32'h0, 4'h0);
        checks++; if (ack_cyc !== 1 || got_err !== 1'b1 || got_rdata !== 32'd0) begin
            errors++; $display("FAIL rej_high got ack %0d err %b rdata %h want 1 1 0", ack_cyc, got_err, got_rdata); end
        checks++; if (n_act[0] !== 0 || n_act[1] !== 0) begin
            errors++; $display("FAIL rej_high_strobes got %0d/%0d want 0/0", n_act[0], n_act[1]); end
        run_txn(1'b1, 32'h0000_0002, 32'h5A5A_5A5A, 4'hF);
        checks++; if (ack_cyc !== 1 || got_err !== 1'b1 || got_rdata !== 32'd0) begin
            errors++; $display("FAIL rej_align got ack %0d err %b rdata %h want 1 1 0", ack_cyc, got_err, got_rdata); end
        checks++; if (n_act[0] !== 0 || n_act[1] !== 0 || n_drv[0] !== 0) begin
            errors++; $display("FAIL rej_align_strobes got %0d/%0d drv %0d want 0/0 0", n_act[0], n_act[1], n_drv[0]); end
    endtask

    task automatic test_be_zero();
        run_txn(1'b1, 32'h0000_0010, 32'h0102_0304, 4'h0);
        checks++; if (n_we[0] !== 1 || ack_cyc !== 4) begin errors++; $display("FAIL bez_cycle got we_low %0d ack %0d want 1 4", n_we[0], ack_cyc); end
        checks++; if (base_mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bez_mem got %h want deadbeef", base_mem[4]); end
    endtask

    task automatic test_reset_mid();
        int late_acks;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0000_0020;
        bus.wdata_i = 32'h5555_AAAA; bus.be_i = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++; if (base_we_n_o !== 1'b0) begin errors++; $display("FAIL mid_we_active got %b want 0", base_we_n_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (base_we_n_o !== 1'b1 || base_ce_n_o !== 1'b1) begin
            errors++; $display("FAIL mid_async_release got we %b ce %b want 1 1", base_we_n_o, base_ce_n_o); end
        bus.req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ack_o !== 1'b0) late_acks++;
        end
        checks++; if (late_acks !== 0) begin errors++; $display("FAIL mid_no_ack got %0d ack cycles want 0", late_acks); end
        @(posedge clk);
        #1;
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        checks++; if (got_rdata !== 32'hDEAD_BEEF || ack_cyc !== 3) begin
            errors++; $display("FAIL mid_readback got %h ack %0d want deadbeef 3", got_rdata, ack_cyc); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
        test_reset();
        test_write_base();
        test_read_base();
        test_write_ext();
        test_reject();
        test_be_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
